// File: rtl/pix_normalizer_if.sv
// Pixel write stream into the normalizer and normalized write stream out to image_mem.
// Ports: in_wr/in_addr/in_pix come from the compressor; out_wr/out_addr/out_pix go to image_mem.
// busy, done and overrun report the block's phase and any dropped input writes.
interface pix_normalizer_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
);
  logic              in_wr;
  logic [ADDR_W-1:0] in_addr;
  logic [PIX_W-1:0]  in_pix;
  logic              out_wr;
  logic [ADDR_W-1:0] out_addr;
  logic [PIX_W-1:0]  out_pix;
  logic              busy;
  logic              done;
  logic              overrun;

  // Compressor / test side: produces pixel writes and observes the results.
  modport master (
    output in_wr, in_addr, in_pix,
    input  out_wr, out_addr, out_pix, busy, done, overrun
  );

  // Normalizer side.
  modport slave (
    input  in_wr, in_addr, in_pix,
    output out_wr, out_addr, out_pix, busy, done, overrun
  );
endinterface

// File: rtl/pix_normalizer.sv
// Captures a 784-pixel frame while tracking min/max, then writes an inverted contrast-stretched copy.
// Latency: pixel k is written 19*(k+1) cycles after the final capture write; done follows 1 cycle after the last write.
// No backpressure: input writes arriving while busy are dropped and flagged via the sticky overrun output.
// Ports: clk, rst (sync, active-high), bus (slave modport of pix_normalizer_if).
module pix_normalizer #(
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 784,
  parameter int ADDR_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  pix_normalizer_if.slave bus
);

  localparam int NUM_W = 2 * PIX_W;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = {PIX_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_W - 1);

  typedef enum logic [2:0] {S_CAPTURE, S_FETCH, S_LOAD, S_DIV, S_WR, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [PIX_W-1:0]  min_q, min_d, max_q, max_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [PIX_W-1:0]  den_q, den_d;
  logic [PIX_W-1:0]  rem_q, rem_d;
  logic [PIX_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic              force0_q, force0_d, force1_q, force1_d;
  logic              out_wr_q, out_wr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [PIX_W-1:0]  out_pix_q, out_pix_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic [PIX_W-1:0]  mem [NUM_PIX];
  logic [PIX_W-1:0]  rd_q;
  logic              mem_we;
  logic              accept;
  logic              busy_w;
  logic [PIX_W:0]    rem_sh;
  logic              qbit;
  logic [PIX_W-1:0]  diff;
  logic [PIX_W-1:0]  q_final;

  assign busy_w = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                  (state_q == S_DIV)   || (state_q == S_WR);
  assign accept = bus.in_wr && (bus.in_addr <= LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    min_d      = min_q;
    max_d      = max_q;
    num_d      = num_q;
    den_d      = den_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_cnt_d  = div_cnt_q;
    force0_d   = force0_q;
    force1_d   = force1_q;
    out_wr_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_pix_d  = out_pix_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q | (busy_w & bus.in_wr);
    mem_we     = 1'b0;
    rem_sh     = '0;
    qbit       = 1'b0;
    diff       = '0;
    q_final    = '0;

    case (state_q)
      S_CAPTURE: begin
        if (accept) begin
          mem_we = !rst;
          if (bus.in_pix < min_q) min_d = bus.in_pix;
          if (bus.in_pix > max_q) max_d = bus.in_pix;
          if (bus.in_addr == LAST_ADDR) begin
            state_d = S_FETCH;
            k_d     = '0;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        diff      = max_q - rd_q;
        num_d     = {{PIX_W{1'b0}}, diff} * {{PIX_W{1'b0}}, PIX_MAX};
        den_d     = max_q - min_q;
        // A flat (or empty) frame yields 0; stale pixels outside [min,max] clamp to the rails.
        force0_d  = (max_q <= min_q) || (rd_q > max_q);
        force1_d  = !((max_q <= min_q) || (rd_q > max_q)) && (rd_q < min_q);
        rem_d     = '0;
        quo_d     = '0;
        div_cnt_d = '0;
        state_d   = S_DIV;
      end
      S_DIV: begin
        // Restoring division, one quotient bit per cycle, numerator MSB first.
        rem_sh = {rem_q, num_q[NUM_W-1]};
        if (rem_sh >= {1'b0, den_q}) begin
          qbit  = 1'b1;
          rem_d = PIX_W'(rem_sh - {1'b0, den_q});
        end else begin
          rem_d = rem_sh[PIX_W-1:0];
        end
        num_d     = num_q << 1;
        quo_d     = (quo_q << 1) | {{(PIX_W-1){1'b0}}, qbit};
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (div_cnt_q == CNT_LAST) begin
          if (force0_q)      q_final = '0;
          else if (force1_q) q_final = PIX_MAX;
          else               q_final = quo_d;
          out_wr_d   = 1'b1;
          out_addr_d = k_q;
          out_pix_d  = q_final;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (k_q == LAST_ADDR) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        min_d   = PIX_MAX;
        max_d   = '0;
        state_d = S_CAPTURE;
      end
      default: state_d = S_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CAPTURE;
      k_q        <= '0;
      min_q      <= PIX_MAX;
      max_q      <= '0;
      num_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_cnt_q  <= '0;
      force0_q   <= 1'b0;
      force1_q   <= 1'b0;
      out_wr_q   <= 1'b0;
      out_addr_q <= '0;
      out_pix_q  <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      min_q      <= min_d;
      max_q      <= max_d;
      num_q      <= num_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_cnt_q  <= div_cnt_d;
      force0_q   <= force0_d;
      force1_q   <= force1_d;
      out_wr_q   <= out_wr_d;
      out_addr_q <= out_addr_d;
      out_pix_q  <= out_pix_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame buffer: contents survive reset so unwritten addresses keep older pixels.
  always_ff @(posedge clk) begin
    if (mem_we) mem[bus.in_addr] <= bus.in_pix;
    if (state_q == S_FETCH) rd_q <= mem[k_q];
  end

  assign bus.out_wr   = out_wr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_pix  = out_pix_q;
  assign bus.busy     = busy_w;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_pix_normalizer.sv
module tb_pix_normalizer;
  localparam int NP = 784;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pix_normalizer_if #(.PIX_W(8), .ADDR_W(10)) bus ();

  pix_normalizer #(.PIX_W(8), .NUM_PIX(NP), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int addr;
    int pix;
    int cyc;
  } exp_t;

  int   cyc = 0;
  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_mem[NP];
  int   fmin = 255;
  int   fmax = 0;
  int   got[NP];
  int   out_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: invert and stretch [min,max] onto 255..0; out-of-range stale pixels clamp.
  function automatic int ref_norm(input int p, input int mn, input int mx);
    if (mx <= mn) return 0;
    if (p > mx)   return 0;
    if (p < mn)   return 255;
    return ((mx - p) * 255) / (mx - mn);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_addr", int'(bus.out_addr), e.addr);
        check("out_pix", int'(bus.out_pix), e.pix);
        check("out_wr_cycle", cyc, e.cyc);
        got[e.addr] = int'(bus.out_pix);
        out_cnt++;
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else                    check("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic start_norm(input int t);
    for (int k = 0; k < NP; k++)
      exp_q.push_back('{k, ref_norm(model_mem[k], fmin, fmax), t + 19 * (k + 1)});
    done_q.push_back(t + 19 * NP + 1);
    fmin = 255;
    fmax = 0;
  endtask

  task automatic drive_wr(input int a, input int p);
    @(posedge clk);
    #1;
    bus.in_wr   = 1'b1;
    bus.in_addr = 10'(a);
    bus.in_pix  = 8'(p);
    if (a < NP) begin
      model_mem[a] = p;
      if (p < fmin) fmin = p;
      if (p > fmax) fmax = p;
      if (a == NP - 1) start_norm(cyc);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_wr = 1'b0;
  endtask

  function automatic int gen_pix(input int mode, input int a);
    case (mode)
      0: return a % 256;
      1: return 100;
      2: begin
        if (a == 0) return 50;
        if (a == 1) return 100;
        if (a == 2) return 150;
        return int'($urandom_range(150, 50));
      end
      3: return int'($urandom_range(255, 0));
      default: return int'($urandom_range(180, 80));
    endcase
  endfunction

  task automatic send_frame(input int mode, input int first, input bit junk);
    for (int a = first; a < NP; a++) begin
      if (junk && $urandom_range(3, 0) == 0) drive_wr(900, int'($urandom_range(255, 0)));
      if ($urandom_range(7, 0) == 0) idle();
      drive_wr(a, gen_pix(mode, a));
    end
    idle();
  endtask

  task automatic wait_done();
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 16000) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", int'(done_cnt != start), 1);
    check("leftover_expected", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_wr"}, int'(bus.out_wr), 0);
    check({tag, "_out_addr"}, int'(bus.out_addr), 0);
    check({tag, "_out_pix"}, int'(bus.out_pix), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_overrun"}, int'(bus.overrun), 0);
  endtask

  initial begin
    int c0;
    rst         = 1'b1;
    bus.in_wr   = 1'b0;
    bus.in_addr = '0;
    bus.in_pix  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Ramp frame: min 0, max 255
    c0 = out_cnt;
    send_frame(0, 0, 1'b0);
    check("busy_in_norm", int'(bus.busy), 1);
    wait_done();
    check("ramp_out_count", out_cnt - c0, NP);
    check("ramp_pix0", got[0], 255);
    check("ramp_pix255", got[255], 0);
    check("ramp_pix256", got[256], 255);
    check("ramp_pix783", got[783], 240);

    // Constant frame
    send_frame(1, 0, 1'b0);
    wait_done();
    check("const_pix0", got[0], 0);
    check("const_pix783", got[783], 0);

    // 50..150 frame with junk writes at address 900, plus an overrun write during NORM
    send_frame(2, 0, 1'b1);
    repeat (50) idle();
    check("overrun_before", int'(bus.overrun), 0);
    @(posedge clk);
    #1;
    bus.in_wr   = 1'b1;
    bus.in_addr = 10'd5;
    bus.in_pix  = 8'd9;
    idle();
    check("overrun_set", int'(bus.overrun), 1);
    wait_done();
    check("overrun_sticky", int'(bus.overrun), 1);
    check("mid_pix50", got[0], 255);
    check("mid_pix100", got[1], 127);
    check("mid_pix150", got[2], 0);

    // Random frame aborted by reset while pixel 300 is being divided
    c0 = out_cnt;
    send_frame(3, 0, 1'b0);
    repeat (19 * 300 + 5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    fmin = 255;
    fmax = 0;
    check("abort_out_count", out_cnt - c0, 300);
    @(negedge clk);
    check_all_zero("abort");
    c0 = out_cnt;
    repeat (100) @(posedge clk);
    check("abort_no_more_wr", out_cnt - c0, 0);

    // Partial frame: addresses 0..399 keep stale random pixels and clamp
    send_frame(4, 400, 1'b0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
